// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: merges the inst and data SRAM-like ports onto one AXI master.
// One transaction in flight at a time; the data port has fixed priority.
module cpu_axi_bridge #(
    parameter logic [3:0] ID_INST = 4'd0,
    parameter logic [3:0] ID_DATA = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        idle;
    logic        take_data;
    logic        take_inst;
    logic        rd_fire;
    logic        own_data;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] inst_rdata_q;
    logic [31:0] data_rdata_q;
    logic        aw_done;
    logic        w_done;
    logic        inst_ok_q;
    logic        data_ok_q;
    logic        unused_rid;

    // Gated by resetn so no addr_ok leaks out while reset is held.
    assign idle      = (state == IDLE) && resetn;
    assign take_data = idle && data_req;
    assign take_inst = idle && inst_req && !data_req;
    assign rd_fire   = (state == RD_DATA) && rvalid;
    assign unused_rid = ^rid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (take_data) begin
                    state_nx = data_wr ? WR_REQ : RD_ADDR;
                end else if (take_inst) begin
                    state_nx = RD_ADDR;
                end
            end
            RD_ADDR: if (arready) state_nx = RD_DATA;
            RD_DATA: if (rvalid) state_nx = IDLE;
            WR_REQ: begin
                if ((aw_done || awready) && (w_done || wready)) begin
                    state_nx = WR_RESP;
                end
            end
            WR_RESP: if (bvalid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        inst_addr_ok = take_inst;
        data_addr_ok = take_data;
        arvalid      = 1'b0;
        arid         = 4'd0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        awid         = 4'd0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        unique case (state)
            RD_ADDR: begin
                arvalid = 1'b1;
                arid    = own_data ? ID_DATA : ID_INST;
            end
            RD_DATA: rready = 1'b1;
            WR_REQ: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                awid    = ID_DATA;
            end
            WR_RESP: bready = 1'b1;
            default: ;
        endcase
    end

    assign araddr       = addr_q;
    assign awaddr       = addr_q;
    assign wdata        = wdata_q;
    assign wstrb        = wstrb_q;
    assign inst_rdata   = inst_rdata_q;
    assign data_rdata   = data_rdata_q;
    assign inst_data_ok = inst_ok_q;
    assign data_data_ok = data_ok_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            own_data     <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            wstrb_q      <= 4'd0;
            inst_rdata_q <= 32'd0;
            data_rdata_q <= 32'd0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            inst_ok_q    <= 1'b0;
            data_ok_q    <= 1'b0;
        end else begin
            if (take_data) begin
                own_data <= 1'b1;
                addr_q   <= data_addr;
                wdata_q  <= data_wdata;
                wstrb_q  <= data_wstrb;
            end else if (take_inst) begin
                own_data <= 1'b0;
                addr_q   <= inst_addr;
            end
            // Each write channel retires on its own handshake.
            aw_done <= (state == WR_REQ) && (aw_done || awready);
            w_done  <= (state == WR_REQ) && (w_done || wready);
            if (rd_fire && own_data) data_rdata_q <= rdata;
            if (rd_fire && !own_data) inst_rdata_q <= rdata;
            inst_ok_q <= rd_fire && !own_data;
            data_ok_q <= (rd_fire && own_data)
                      || ((state == WR_RESP) && bvalid);
        end
    end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb_cpu_axi_bridge: random-delay AXI slave plus a word-memory reference
// model on the core side; every check goes through chk.
module tb_cpu_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  arid, rid, awid, wstrb;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;

    cpu_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    int rst_epoch = 0;
    int inst_oks = 0, data_oks = 0;
    logic [31:0] smem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [3:0]  idq [$];

    task automatic chk(input string tag, input logic [191:0] got,
                       input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] smem_rd(input logic [31:0] a);
        return smem.exists(a) ? smem[a] : ~a;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : ~a;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [3:0] s,
                                          input logic [31:0] d);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~m) | (d & m);
    endfunction

    function automatic logic [191:0] outs();
        return {11'd0, inst_addr_ok, inst_data_ok, inst_rdata,
                data_addr_ok, data_data_ok, data_rdata,
                arid, araddr, arvalid, rready,
                awid, awaddr, awvalid, wdata, wstrb, wvalid, bready};
    endfunction

    function automatic logic [31:0] pool();
        return 32'h2000 + 32'(4 * $urandom_range(0, 15));
    endfunction

    always @(negedge resetn) rst_epoch++;

    // Expected AXI id per accepted request, in acceptance order.
    always @(negedge clk) begin
        if (resetn) begin
            if (data_addr_ok) idq.push_back(4'd1);
            else if (inst_addr_ok) idq.push_back(4'd0);
            if (inst_data_ok) inst_oks++;
            if (data_data_ok) data_oks++;
        end
    end

    initial begin : rd_slave
        logic [31:0] a;
        logic [3:0]  id, e;
        int ep, n;
        bit hs;
        arready = 0; rvalid = 0; rdata = 0; rid = 0;
        forever begin
            @(negedge clk);
            if (resetn && arvalid) begin
                a = araddr; id = arid; ep = rst_epoch;
                e = (idq.size() > 0) ? idq.pop_front() : 4'hF;
                chk("arid", id, e);
                repeat (ar_dly) begin
                    @(negedge clk);
                    chk("ar_hold", {arvalid, araddr}, {1'b1, a});
                end
                arready = 1;
                @(posedge clk); #1 arready = 0;
                repeat (r_dly) @(negedge clk);
                if (ep == rst_epoch) begin
                    rvalid = 1; rdata = smem_rd(a); rid = id;
                    hs = 0; n = 0;
                    while (!hs && n < 50 && ep == rst_epoch) begin
                        hs = rready;
                        @(posedge clk); #1;
                        n++;
                    end
                    rvalid = 0;
                    if (ep == rst_epoch) chk("r_handshake", hs, 1'b1);
                end
            end
        end
    end

    initial begin : wr_slave
        logic [31:0] a, d;
        logic [3:0]  s, id, e;
        int ca, cw, n;
        bit ad, wd, hs;
        awready = 0; wready = 0; bvalid = 0;
        forever begin
            @(negedge clk);
            if (resetn && (awvalid || wvalid)) begin
                a = awaddr; d = wdata; s = wstrb; id = awid;
                e = (idq.size() > 0) ? idq.pop_front() : 4'hF;
                chk("awid", id, e);
                ca = aw_dly; cw = w_dly; ad = 0; wd = 0; n = 0;
                while (!(ad && wd) && n < 50) begin
                    if (!ad) begin
                        chk("aw_hold", {awvalid, awaddr}, {1'b1, a});
                        awready = (ca == 0);
                        if (ca > 0) ca--;
                    end else chk("aw_drop", awvalid, 1'b0);
                    if (!wd) begin
                        chk("w_hold", {wvalid, wdata, wstrb}, {1'b1, d, s});
                        wready = (cw == 0);
                        if (cw > 0) cw--;
                    end else chk("w_drop", wvalid, 1'b0);
                    chk("bready_early", bready, 1'b0);
                    @(posedge clk); #1;
                    if (awready) begin ad = 1; awready = 0; end
                    if (wready) begin wd = 1; wready = 0; end
                    n++;
                    if (!(ad && wd)) @(negedge clk);
                end
                chk("w_complete", {ad, wd}, 2'b11);
                smem[a] = merge(smem_rd(a), s, d);
                repeat (b_dly) @(negedge clk);
                bvalid = 1; hs = 0; n = 0;
                while (!hs && n < 50) begin
                    hs = bready;
                    @(posedge clk); #1;
                    n++;
                end
                bvalid = 0;
                chk("b_handshake", hs, 1'b1);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // One request on either port, checked against the reference memory.
    task automatic xfer(input bit is_data, input bit wr, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d);
        logic [31:0] e;
        int n;
        if (is_data) begin
            data_req = 1; data_wr = wr; data_addr = a;
            data_wstrb = s; data_wdata = d;
        end else begin
            inst_req = 1; inst_addr = a;
        end
        n = 0;
        @(negedge clk);
        while (!(is_data ? data_addr_ok : inst_addr_ok) && n < 100) begin
            @(negedge clk); n++;
        end
        chk("xfer_addr_ok", is_data ? data_addr_ok : inst_addr_ok, 1'b1);
        e = ref_rd(a);
        if (wr) ref_mem[a] = merge(e, s, d);
        tick();
        data_req = 0; inst_req = 0;
        n = 0;
        @(negedge clk);
        while (!(is_data ? data_data_ok : inst_data_ok) && n < 100) begin
            @(negedge clk); n++;
        end
        chk("xfer_data_ok", is_data ? data_data_ok : inst_data_ok, 1'b1);
        if (!wr) chk("xfer_rdata", is_data ? data_rdata : inst_rdata, e);
        tick();
    endtask

    // Both ports request at once; data must win and inst follows back-to-back.
    task automatic pair(input logic [31:0] a);
        logic [31:0] e;
        int n;
        e = ref_rd(a);
        inst_req = 1; inst_addr = 32'h1C00_0000;
        data_req = 1; data_wr = 0; data_addr = a;
        @(negedge clk);
        chk("pair_arb", {data_addr_ok, inst_addr_ok}, 2'b10);
        tick();
        data_req = 0;
        n = 0;
        @(negedge clk);
        while (!data_data_ok && n < 100) begin
            chk("pair_busy_no_ack", inst_addr_ok, 1'b0);
            @(negedge clk); n++;
        end
        chk("pair_dok", data_data_ok, 1'b1);
        chk("pair_rdata", data_rdata, e);
        chk("pair_b2b_ack", inst_addr_ok, 1'b1);
        tick();
        inst_req = 0;
        n = 0;
        @(negedge clk);
        while (!inst_data_ok && n < 100) begin
            @(negedge clk); n++;
        end
        chk("pair_iok", inst_data_ok, 1'b1);
        chk("pair_irdata", inst_rdata, ref_rd(32'h1C00_0000));
        tick();
    endtask

    initial begin : main
        logic [3:0]  v;
        logic [31:0] a, d;
        int n, d0, acc, done, cyc;
        bit got_acc;
        logic [31:0] q [$];
        resetn = 0;
        inst_req = 0; inst_addr = 0;
        data_req = 0; data_wr = 0; data_wstrb = 0;
        data_addr = 0; data_wdata = 0;
        smem[32'h1C00_0000] = 32'h0280_0C0C;
        smem[32'h0000_0080] = 32'hDEAD_0080;
        smem[32'h0000_0100] = 32'h1234_5678;
        for (int i = 0; i < 16; i++) smem[32'h2000 + 32'(4 * i)] = $urandom;
        foreach (smem[k]) ref_mem[k] = smem[k];

        repeat (3) @(negedge clk);
        chk("reset_outs", outs(), 192'd0);
        resetn = 1;
        tick();
        chk("post_reset_outs", outs(), 192'd0);

        // Single inst read with zero-wait slave: data_ok lands in N+3.
        inst_req = 1; inst_addr = 32'h1C00_0000;
        @(negedge clk);
        chk("t1_addr_ok", inst_addr_ok, 1'b1);
        tick();
        inst_req = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            v[i] = inst_data_ok;
            if (i == 0)
                chk("t1_ar", {arvalid, arid, araddr}, {1'b1, 4'd0, 32'h1C00_0000});
        end
        chk("t1_ok_timing", v, 4'b0100);
        chk("t1_rdata", inst_rdata, 32'h0280_0C0C);
        tick();

        pair(32'h80);

        aw_dly = 0; w_dly = 3; b_dly = 1;
        d0 = data_oks;
        xfer(1, 1, 32'h100, 4'h3, 32'h0000_ABCD);
        chk("t3_one_ok", data_oks - d0, 1);
        w_dly = 0; b_dly = 0;
        xfer(1, 0, 32'h100, 4'h0, 32'h0);
        chk("t3_merged", data_rdata, 32'h1234_ABCD);

        ar_dly = 5;
        pair(32'h84);
        ar_dly = 0;

        // Reset while the read data phase is pending.
        r_dly = 10;
        inst_req = 1; inst_addr = 32'h1C00_0004;
        n = 0;
        @(negedge clk);
        while (!inst_addr_ok && n < 50) begin @(negedge clk); n++; end
        tick();
        inst_req = 0;
        n = 0;
        @(negedge clk);
        while (!rready && n < 50) begin @(negedge clk); n++; end
        chk("t5_in_rd_data", rready, 1'b1);
        #2 resetn = 0;
        #1 chk("t5_async_clear", outs(), 192'd0);
        d0 = inst_oks;
        repeat (2) @(negedge clk);
        resetn = 1;
        repeat (15) @(negedge clk);
        chk("t5_no_spurious", inst_oks - d0, 0);
        r_dly = 0;
        tick();
        d0 = inst_oks;
        xfer(0, 0, 32'h1C00_0000, 4'h0, 32'h0);
        chk("t5_fresh_ok", inst_oks - d0, 1);

        for (int i = 0; i < 8; i++) begin
            aw_dly = $urandom_range(0, 3);
            w_dly = $urandom_range(0, 3);
            b_dly = $urandom_range(0, 3);
            a = pool(); d = $urandom;
            xfer(1, 1, a, 4'($urandom_range(1, 15)), d);
        end

        // Back-to-back data reads with random slave timing.
        d0 = data_oks; acc = 0; done = 0; cyc = 0;
        ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
        data_req = 1; data_wr = 0; data_addr = pool();
        while (done < 20 && cyc < 2000) begin
            @(negedge clk);
            got_acc = data_addr_ok;
            if (data_data_ok) begin
                chk("b2b_pending", q.size() > 0, 1'b1);
                if (q.size() > 0) chk("b2b_rdata", data_rdata, q.pop_front());
                done++;
            end
            if (got_acc) begin
                q.push_back(ref_rd(data_addr));
                acc++;
            end
            tick();
            cyc++;
            if (got_acc) begin
                if (acc < 20) begin
                    data_addr = pool();
                    ar_dly = $urandom_range(0, 3);
                    r_dly = $urandom_range(0, 3);
                end else data_req = 0;
            end
        end
        data_req = 0;
        chk("b2b_done", done, 20);
        chk("b2b_acc", acc, 20);
        chk("b2b_ok_cnt", data_oks - d0, 20);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
